fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage redirect controller sitting directly in front of the program counter register. Each cycle it decides the next PC value (`npc`) and the PC write enable (`pc_en`) by arbitrating between sequential fetch, branch/jump redirects from ID, exception entry and `eret` from the CP0/M-stage side, and the hazard-unit stall. A branch redirect that arrives during a stall is buffered and replayed when the stall releases. A one-cycle post-exception squash window blocks wrong-path branch redirects.

## Interface

- `TEXT_START`, 32'h0000_3000, PC value driven while reset is asserted
- `EXC_HANDLER`, 32'h0000_4180, exception entry address
- `CNT_W`, 16, width of the redirect event counter

Ports:

- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately
- `stall` in 1: hazard-unit stall; 1 = IF must not advance
- `pc` in 32: current PC register value
- `br_req` in 1: ID has a taken branch/jump this cycle
- `br_target` in 32: target for `br_req`
- `exc_req` in 1: exception/interrupt taken this cycle
- `eret_req` in 1: `eret` committing this cycle
- `epc` in 32: return address for `eret_req`
- `npc` out 32: next PC value to load
- `pc_en` out 1: PC write enable
- `flush_if` out 1: kill the instruction currently in IF/ID
- `pending` out 1: a buffered branch redirect is held
- `redirect_cnt` out `CNT_W`: count of applied non-sequential redirects

## Operation

- State machine, 2-bit encoded:
  - RUN: normal fetch.
  - PEND: a branch target is held in `pend_tgt`.
  - SQUASH: the one cycle after an exception or `eret` redirect.
- Source priority, highest first, evaluated combinationally every cycle:
  1. `exc_req`: `npc=EXC_HANDLER`, `pc_en=1` even if `stall=1`, `flush_if=1`. Next state is SQUASH; `pend_tgt` is discarded.
  2. `eret_req`: `npc=epc`, `pc_en=1` even if `stall=1`, `flush_if=1`. Next state is SQUASH; `pend_tgt` is discarded.
  3. State PEND:
     - `stall=0`: `npc=pend_tgt`, `pc_en=1`, next state RUN.
     - `stall=1`: `pc_en=0`, stay in PEND.
     - `br_req` is ignored in PEND, because it is the same held branch.
  4. State SQUASH:
     - `br_req` is ignored (wrong path).
     - `npc=pc+4`, `pc_en=!stall`.
     - Next state RUN unconditionally.
  5. State RUN with `br_req`:
     - `stall=0`: `npc=br_target`, `pc_en=1`, stay in RUN.
     - `stall=1`: latch `pend_tgt<=br_target`, `pc_en=0`, next state PEND.
  6. Otherwise: `npc=pc+4`, `pc_en=!stall`.
- `flush_if` is 0 for branch redirects, because the delay slot executes.
- `pc+4` is a 32-bit add that wraps modulo 2^32; 32'hFFFF_FFFC gives 0.
- `br_target` and `epc` pass through unmodified. Alignment faults are detected elsewhere.
- `exc_req` and `eret_req` both high: `exc_req` wins and `eret_req` is dropped.
- `redirect_cnt`:
  - Increments on each edge where `pc_en=1` and `npc` came from an exception, `eret`, pending or branch source.
  - Sequential +4 does not count.
  - Wraps at 2^`CNT_W`.
- `pending` = (state == PEND).

## Timing

- While `reset=0`, asynchronously:
  - State RUN, `pend_tgt=0`, `redirect_cnt=0`.
  - Outputs `npc=TEXT_START`, `pc_en=0`, `flush_if=0`, `pending=0`.
- All outputs are combinational from inputs and state. The PC loads `npc` at the same rising edge, so a redirect takes effect one edge after the request.
- A buffered redirect is applied at the first edge where `stall=0`. The delay equals the number of stall cycles; there is no extra bubble.
- Reset asserted mid-PEND or mid-SQUASH drops the held target. After release, fetch resumes in RUN from `TEXT_START`.
- The SQUASH window is exactly one cycle and is independent of `stall`.

## Test plan

- Reset release, no requests, `stall=0` for 4 cycles, `pc=0x3000..` -> `npc` = 0x3004, 0x3008, 0x300C, 0x3010; `pc_en=1`; `redirect_cnt=0`.
- RUN, `br_req=1`, `br_target=0x3100`, `stall=0` -> `npc=0x3100`, `pc_en=1`, `flush_if=0`, `redirect_cnt=1`.
- `br_req=1`, target 0x3200, with `stall=1` held 3 cycles -> `pending=1` and `pc_en=0` for 3 cycles, then `npc=0x3200`, `pc_en=1`, `pending=0`.
- PEND holding 0x3200, `exc_req=1` with `stall=1` -> `npc=0x4180`, `pc_en=1`, `flush_if=1`, `pending=0`. Next cycle `br_req=1` (0x3300) is ignored: `npc=pc+4`.
- `exc_req=1` and `eret_req=1` (`epc=0x3050`) in the same cycle -> `npc=0x4180`. Then `eret_req` alone -> `npc=0x3050`, `flush_if=1`.
- `pc=0xFFFF_FFFC`, no request -> `npc=0`. Assert `reset=0` mid-PEND -> `npc=0x3000`, `pending=0` immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage redirect controller: picks the next PC among sequential fetch,
// branch, buffered branch, exception entry and eret, honouring the IF stall.
module fetch_ctrl #(
  parameter logic [31:0] TEXT_START  = 32'h0000_3000,
  parameter logic [31:0] EXC_HANDLER = 32'h0000_4180,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      pc,
  input  logic             br_req,
  input  logic [31:0]      br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  output logic [31:0]      npc,
  output logic             pc_en,
  output logic             flush_if,
  output logic             pending,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  // Which rule owns this cycle; both next-state and output logic key off it.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_EXC,
    SRC_ERET,
    SRC_PEND,
    SRC_BR,
    SRC_BR_DEFER,
    SRC_HOLD
  } src_t;

  state_t      state_q, state_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  src_t        src;
  logic        redirect;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Priority arbitration: exception, eret, held branch, squash, live branch.
  always_comb begin
    src = SRC_SEQ;
    if (exc_req) begin
      src = SRC_EXC;
    end else if (eret_req) begin
      src = SRC_ERET;
    end else begin
      unique case (state_q)
        ST_PEND:   src = stall ? SRC_HOLD : SRC_PEND;
        ST_SQUASH: src = SRC_SEQ;
        default:   if (br_req) src = stall ? SRC_BR_DEFER : SRC_BR;
      endcase
    end
  end

  // NOTE: every comb output gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    unique case (src)
      SRC_EXC, SRC_ERET: begin
        state_d    = ST_SQUASH;
        pend_tgt_d = '0;
      end
      SRC_BR_DEFER: begin
        state_d    = ST_PEND;
        pend_tgt_d = br_target;
      end
      SRC_HOLD: state_d = ST_PEND;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    npc      = pc + 32'd4;
    pc_en    = !stall;
    flush_if = 1'b0;
    redirect = 1'b0;
    unique case (src)
      SRC_EXC: begin
        npc      = EXC_HANDLER;
        pc_en    = 1'b1;
        flush_if = 1'b1;
        redirect = 1'b1;
      end
      SRC_ERET: begin
        npc      = epc;
        pc_en    = 1'b1;
        flush_if = 1'b1;
        redirect = 1'b1;
      end
      SRC_PEND: begin
        npc      = pend_tgt_q;
        pc_en    = 1'b1;
        redirect = 1'b1;
      end
      SRC_BR: begin
        npc      = br_target;
        pc_en    = 1'b1;
        redirect = 1'b1;
      end
      SRC_BR_DEFER: begin
        npc   = br_target;
        pc_en = 1'b0;
      end
      SRC_HOLD: begin
        npc   = pend_tgt_q;
        pc_en = 1'b0;
      end
      default: ;
    endcase
    // The PC register sees TEXT_START for as long as reset is held.
    if (!reset) begin
      npc      = TEXT_START;
      pc_en    = 1'b0;
      flush_if = 1'b0;
      redirect = 1'b0;
    end
  end

  assign pending = (state_q == ST_PEND);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_cnt <= '0;
    end else if (pc_en && redirect) begin
      redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised and directed bench for fetch_ctrl against a rule-level model
// that tracks "a branch is held" / "inside squash window" as plain flags.
module tb_fetch_ctrl;

  localparam logic [31:0] TEXT_START  = 32'h0000_3000;
  localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc = TEXT_START;
  logic        br_req = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] npc;
  logic        pc_en;
  logic        flush_if;
  logic        pending;
  logic [15:0] redirect_cnt;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc           (pc),
    .br_req       (br_req),
    .br_target    (br_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .npc          (npc),
    .pc_en        (pc_en),
    .flush_if     (flush_if),
    .pending      (pending),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: flags rather than an encoded state.
  bit          m_held;
  logic [31:0] m_held_tgt;
  bit          m_after_trap;
  logic [15:0] m_cnt;

  task automatic model_clear();
    m_held       = 0;
    m_held_tgt   = '0;
    m_after_trap = 0;
    m_cnt        = '0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // advance model and PC at the rising edge.
  task automatic cycle(input logic b, input logic [31:0] t, input logic e,
                       input logic r, input logic [31:0] ep, input logic s);
    logic [31:0] x_npc;
    bit          x_en, x_flush, x_redir, n_held, n_trap;
    logic [31:0] n_tgt;
    br_req = b; br_target = t; exc_req = e; eret_req = r; epc = ep; stall = s;
    x_npc = pc + 32'd4; x_en = !s; x_flush = 0; x_redir = 0;
    n_held = m_held; n_tgt = m_held_tgt; n_trap = 0;
    if (e || r) begin
      x_npc = e ? EXC_HANDLER : ep;
      x_en = 1; x_flush = 1; x_redir = 1;
      n_held = 0; n_trap = 1;
    end else if (m_held) begin
      if (!s) begin
        x_npc = m_held_tgt; x_en = 1; x_redir = 1; n_held = 0;
      end
    end else if (m_after_trap) begin
      // wrong-path branch dropped; plain sequential fetch
    end else if (b) begin
      if (!s) begin
        x_npc = t; x_en = 1; x_redir = 1;
      end else begin
        n_held = 1; n_tgt = t;
      end
    end
    @(negedge clk);
    check("pc_en", {31'd0, pc_en}, {31'd0, x_en});
    if (x_en) check("npc", npc, x_npc);
    check("flush_if", {31'd0, flush_if}, {31'd0, x_flush});
    check("pending", {31'd0, pending}, {31'd0, m_held});
    check("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, m_cnt});
    @(posedge clk);
    if (x_en && x_redir) m_cnt = m_cnt + 16'd1;
    m_held = n_held; m_held_tgt = n_tgt; m_after_trap = n_trap;
    #1;
    if (x_en) pc = x_npc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, '0, 0);
  endtask

  // Assert reset between edges, check the asynchronous response, release.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_npc", npc, TEXT_START);
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_flush", {31'd0, flush_if}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    pc = TEXT_START;
  endtask

  initial begin
    model_clear();
    br_req = 0; exc_req = 0; eret_req = 0; stall = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Sequential fetch from TEXT_START.
    idle(4);
    check("seq_pc", pc, 32'h0000_3010);

    // Unstalled branch.
    cycle(1, 32'h0000_3100, 0, 0, '0, 0);
    check("br_pc", pc, 32'h0000_3100);

    // Branch under a 3-cycle stall, replayed on release with no bubble.
    for (int i = 0; i < 3; i++) cycle(1, 32'h0000_3200, 0, 0, '0, 1);
    cycle(1, 32'h0000_3200, 0, 0, '0, 0);
    check("pend_pc", pc, 32'h0000_3200);

    // Exception pre-empts a held branch under stall, then squash window.
    cycle(1, 32'h0000_3300, 0, 0, '0, 1);
    cycle(0, '0, 1, 0, '0, 1);
    check("exc_pc", pc, EXC_HANDLER);
    cycle(1, 32'h0000_3300, 0, 0, '0, 0);
    check("squash_pc", pc, EXC_HANDLER + 32'd4);

    // exc and eret together: exception wins; then eret alone.
    cycle(0, '0, 1, 1, 32'h0000_3050, 0);
    check("exc_eret_pc", pc, EXC_HANDLER);
    idle(1);
    cycle(0, '0, 0, 1, 32'h0000_3050, 0);
    check("eret_pc", pc, 32'h0000_3050);
    idle(1);

    // PC wrap.
    pc = 32'hFFFF_FFFC;
    idle(1);
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset while a branch is held.
    cycle(1, 32'h0000_3400, 0, 0, '0, 1);
    do_reset();
    idle(2);
    check("post_rst_pc", pc, 32'h0000_3008);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t, ep;
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 19) == 0)
        pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      t  = $urandom();
      ep = $urandom();
      cycle($urandom_range(0, 3) == 0, t,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, ep,
            $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
